// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage and IF/ID pipeline register.
//
// Holds the PC and issues one fetch at a time to instruction memory over a
// valid/ready request channel. The word comes back on a valid-only response
// channel and is presented to decode.
//
// A one-entry hold buffer catches a response that arrives while decode is
// stalled. A taken branch redirects the PC. If a fetch is still in flight when
// the branch arrives, that fetch's response is thrown away.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_req_valid/addr/ready     fetch request (addr = current PC)
//   imem_rsp_valid/data           fetch response
//   stall                         hold IF/ID and the hold buffer
//   redirect_valid/pc             taken branch and its target
//   if_id_valid/pc/instr/opcode   IF/ID entry; instr reads NOP_INSTR when invalid
module fetch_stage #(
    parameter int unsigned       XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = '0,
    parameter logic [XLEN-1:0]   NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic [6:0]      if_id_opcode
);

    typedef enum logic [1:0] {StReq, StWait, StKill} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            hb_valid_q, hb_valid_d;
    logic [XLEN-1:0] hb_pc_q, hb_pc_d;
    logic [XLEN-1:0] hb_instr_q, hb_instr_d;
    logic            if_id_valid_q, if_id_valid_d;
    logic [XLEN-1:0] if_id_pc_q, if_id_pc_d;
    logic [XLEN-1:0] if_id_instr_q, if_id_instr_d;

    logic req_fire;
    logic rsp_accept;

    // A full hold buffer blocks new fetches, so WAIT never sees hb_valid set.
    assign imem_req_valid = (state_q == StReq) && !hb_valid_q && !rst;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_accept     = (state_q == StWait) && imem_rsp_valid;

    assign if_id_valid  = if_id_valid_q;
    assign if_id_pc     = if_id_pc_q;
    assign if_id_instr  = if_id_valid_q ? if_id_instr_q : NOP_INSTR;
    assign if_id_opcode = if_id_instr[6:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        hb_valid_d    = hb_valid_q;
        hb_pc_d       = hb_pc_q;
        hb_instr_d    = hb_instr_q;
        if_id_valid_d = if_id_valid_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;

        case (state_q)
            StReq: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    if (!stall) begin
                        if_id_valid_d = 1'b1;
                        if_id_pc_d    = req_pc_q;
                        if_id_instr_d = imem_rsp_data;
                    end else begin
                        hb_valid_d = 1'b1;
                        hb_pc_d    = req_pc_q;
                        hb_instr_d = imem_rsp_data;
                    end
                    state_d = StReq;
                end
            end
            StKill: begin
                if (imem_rsp_valid) begin
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase

        // No fresh word this cycle: drain the hold buffer or insert a bubble.
        if (!stall && !rsp_accept) begin
            if (hb_valid_q) begin
                if_id_valid_d = 1'b1;
                if_id_pc_d    = hb_pc_q;
                if_id_instr_d = hb_instr_q;
                hb_valid_d    = 1'b0;
            end else begin
                if_id_valid_d = 1'b0;
            end
        end

        // Redirect wins over stall and over any response this cycle.
        if (redirect_valid) begin
            pc_d          = redirect_pc;
            if_id_valid_d = 1'b0;
            hb_valid_d    = 1'b0;
            // Go to KILL only if a fetch will still be in flight after this edge.
            if (req_fire || ((state_q != StReq) && !imem_rsp_valid)) begin
                state_d = StKill;
            end else begin
                state_d = StReq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StReq;
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            hb_valid_q    <= 1'b0;
            hb_pc_q       <= '0;
            hb_instr_q    <= '0;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            hb_valid_q    <= hb_valid_d;
            hb_pc_q       <= hb_pc_d;
            hb_instr_q    <= hb_instr_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage.
// Phase 1 applies a table of per-cycle vectors covering reset, straight-line
// fetch, stall with the hold buffer, and both redirect cases.
// Phase 2 runs a second instance through backpressure and PC wrap.
// Phase 3 drives random traffic checked against a transaction-level model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst, imem_req_ready, imem_rsp_valid, stall, redirect_valid;
    logic [31:0] imem_rsp_data, redirect_pc;
    logic        imem_req_valid, if_id_valid;
    logic [31:0] imem_req_addr, if_id_pc, if_id_instr;
    logic [6:0]  if_id_opcode;

    logic        b_rst, b_ready, b_rsp_valid, b_stall, b_redir;
    logic [31:0] b_rsp_data, b_rpc;
    logic        b_req_valid, b_if_valid;
    logic [31:0] b_req_addr, b_if_pc, b_if_instr;
    logic [6:0]  b_if_opcode;

    int total = 0;
    int bad = 0;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode)
    );

    fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
        .clk(clk), .rst(b_rst),
        .imem_req_valid(b_req_valid), .imem_req_addr(b_req_addr),
        .imem_req_ready(b_ready), .imem_rsp_valid(b_rsp_valid),
        .imem_rsp_data(b_rsp_data), .stall(b_stall),
        .redirect_valid(b_redir), .redirect_pc(b_rpc),
        .if_id_valid(b_if_valid), .if_id_pc(b_if_pc),
        .if_id_instr(b_if_instr), .if_id_opcode(b_if_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, ready, rsp_valid, stall, redir;
        logic [31:0] data, rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc, e_instr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv,
                                input logic [31:0] d, input logic st, input logic rd,
                                input logic [31:0] rp, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.rst = r; v.ready = rdy; v.rsp_valid = rv; v.data = d; v.stall = st;
        v.redir = rd; v.rpc = rp; v.e_req = er; v.e_addr = ea; v.e_v = ev;
        v.e_pc = ep; v.e_instr = ei;
        return v;
    endfunction

    // Transaction-level reference model state.
    logic [31:0] m_pc, m_addr, m_if_pc, m_if_instr;
    logic        m_out, m_killed, m_if_valid;
    logic [31:0] m_pend_pc[$];
    logic [31:0] m_pend_instr[$];

    vec_t vecs[23];

    initial begin
        logic exp_req, hs, rsp;

        rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        b_rst = 1'b1; b_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_data = '0;
        b_stall = 1'b0; b_redir = 1'b0; b_rpc = '0;

        //              rst rdy rv data          st rd rpc    req addr  v  pc     instr
        vecs[0]  = mk(1, 1, 0, 32'h0,        0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  NOP);
        vecs[1]  = mk(1, 1, 0, 32'h0,        0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  NOP);
        vecs[2]  = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,  1, 32'h0,  0, 32'h0,  NOP);
        vecs[3]  = mk(0, 0, 1, 32'h00500093, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  NOP);
        vecs[4]  = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,  1, 32'h4,  1, 32'h0,  32'h00500093);
        vecs[5]  = mk(0, 0, 1, 32'h00100113, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  NOP);
        vecs[6]  = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,  1, 32'h8,  1, 32'h4,  32'h00100113);
        vecs[7]  = mk(0, 0, 1, 32'h002081B3, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  NOP);
        vecs[8]  = mk(0, 1, 0, 32'h0,        1, 0, 32'h0,  1, 32'hC,  1, 32'h8,  32'h002081B3);
        vecs[9]  = mk(0, 0, 1, 32'h00308233, 1, 0, 32'h0,  0, 32'h0,  1, 32'h8,  32'h002081B3);
        vecs[10] = mk(0, 1, 0, 32'h0,        1, 0, 32'h0,  0, 32'h0,  1, 32'h8,  32'h002081B3);
        vecs[11] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,  0, 32'h0,  1, 32'h8,  32'h002081B3);
        vecs[12] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,  1, 32'h10, 1, 32'hC,  32'h00308233);
        vecs[13] = mk(0, 0, 0, 32'h0,        0, 1, 32'h40, 0, 32'h0,  0, 32'h0,  NOP);
        vecs[14] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  NOP);
        vecs[15] = mk(0, 1, 1, 32'hDEADBEEF, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  NOP);
        vecs[16] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,  1, 32'h40, 0, 32'h0,  NOP);
        vecs[17] = mk(0, 0, 1, 32'h00A00293, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  NOP);
        vecs[18] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,  1, 32'h44, 1, 32'h40, 32'h00A00293);
        vecs[19] = mk(0, 0, 1, 32'h12345678, 0, 1, 32'h80, 0, 32'h0,  0, 32'h0,  NOP);
        vecs[20] = mk(0, 1, 0, 32'h0,        0, 0, 32'h0,  1, 32'h80, 0, 32'h0,  NOP);
        vecs[21] = mk(0, 0, 1, 32'h00100513, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  NOP);
        vecs[22] = mk(0, 0, 0, 32'h0,        0, 0, 32'h0,  1, 32'h84, 1, 32'h80, 32'h00100513);

        // Phase 1: directed table.
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; imem_req_ready = vecs[i].ready;
            imem_rsp_valid = vecs[i].rsp_valid; imem_rsp_data = vecs[i].data;
            stall = vecs[i].stall; redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
            #1;
            check($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vecs[i].e_req));
            if (vecs[i].e_req)
                check($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
            check($sformatf("vec%0d_if_valid", i), 32'(if_id_valid), 32'(vecs[i].e_v));
            if (vecs[i].e_v || vecs[i].rst)
                check($sformatf("vec%0d_if_pc", i), if_id_pc, vecs[i].e_pc);
            check($sformatf("vec%0d_if_instr", i), if_id_instr, vecs[i].e_instr);
            check($sformatf("vec%0d_opcode", i), 32'(if_id_opcode), 32'(vecs[i].e_instr[6:0]));
        end

        // Phase 2: backpressure and PC wrap on the second instance.
        @(negedge clk); b_rst = 1'b1;
        @(negedge clk);
        @(negedge clk); b_rst = 1'b0; b_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("wrap_bp_valid", 32'(b_req_valid), 32'h1);
            check("wrap_bp_addr", b_req_addr, 32'hFFFF_FFFC);
            @(negedge clk);
        end
        b_ready = 1'b1;
        #1;
        check("wrap_hs_valid", 32'(b_req_valid), 32'h1);
        check("wrap_hs_addr", b_req_addr, 32'hFFFF_FFFC);
        @(negedge clk); b_ready = 1'b0; b_rsp_valid = 1'b1; b_rsp_data = 32'h00400093;
        @(negedge clk); b_rsp_valid = 1'b0;
        #1;
        check("wrap_next_valid", 32'(b_req_valid), 32'h1);
        check("wrap_next_addr", b_req_addr, 32'h0);
        check("wrap_if_valid", 32'(b_if_valid), 32'h1);
        check("wrap_if_pc", b_if_pc, 32'hFFFF_FFFC);
        check("wrap_if_instr", b_if_instr, 32'h00400093);

        // Phase 3: random traffic against the model.
        m_pc = '0; m_addr = '0; m_if_pc = '0; m_if_instr = NOP;
        m_out = 1'b0; m_killed = 1'b0; m_if_valid = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst            = (cyc < 2) || ($urandom_range(0, 199) == 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            imem_rsp_valid = m_out && ($urandom_range(0, 2) == 0);
            imem_rsp_data  = $urandom;
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            #1;
            exp_req = !rst && !m_out && (m_pend_pc.size() == 0);
            check("rnd_req_valid", 32'(imem_req_valid), 32'(exp_req));
            if (exp_req) check("rnd_req_addr", imem_req_addr, m_pc);
            check("rnd_if_valid", 32'(if_id_valid), 32'(m_if_valid));
            if (m_if_valid) check("rnd_if_pc", if_id_pc, m_if_pc);
            check("rnd_if_instr", if_id_instr, m_if_valid ? m_if_instr : NOP);
            check("rnd_opcode", 32'(if_id_opcode), m_if_valid ? 32'(m_if_instr[6:0]) : 32'h13);

            hs  = exp_req && imem_req_ready;
            rsp = m_out && imem_rsp_valid;
            if (rst) begin
                m_pc = 32'h0; m_out = 1'b0; m_if_valid = 1'b0; m_if_pc = '0;
                m_pend_pc.delete(); m_pend_instr.delete();
            end else if (redirect_valid) begin
                m_pc = redirect_pc; m_if_valid = 1'b0;
                m_pend_pc.delete(); m_pend_instr.delete();
                if (hs || (m_out && !rsp)) begin
                    m_out = 1'b1; m_killed = 1'b1;
                end else begin
                    m_out = 1'b0;
                end
            end else begin
                if (rsp && !m_killed) begin
                    if (stall) begin
                        m_pend_pc.push_back(m_addr); m_pend_instr.push_back(imem_rsp_data);
                    end else begin
                        m_if_valid = 1'b1; m_if_pc = m_addr; m_if_instr = imem_rsp_data;
                    end
                end else if (!stall) begin
                    if (m_pend_pc.size() > 0) begin
                        m_if_valid = 1'b1;
                        m_if_pc = m_pend_pc.pop_front();
                        m_if_instr = m_pend_instr.pop_front();
                    end else begin
                        m_if_valid = 1'b0;
                    end
                end
                if (rsp) m_out = 1'b0;
                if (hs) begin
                    m_out = 1'b1; m_killed = 1'b0; m_addr = m_pc; m_pc = m_pc + 32'd4;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the pipelined RV32I core. Holds the PC, fetches one instruction at a time from instruction memory over a valid/ready request and valid response interface, and presents the fetched word to decode. `if_id_opcode` drives `main_control.opcode` directly. Honors the hazard unit's stall and the branch redirect (`pc_src`) from the execute stage.

## Interface
- `XLEN`, 32: address/data width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013: word shown on `if_id_instr` when the IF/ID entry is invalid (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req_valid` out 1: fetch request.
- `imem_req_addr` out XLEN: fetch address (current PC).
- `imem_req_ready` in 1: memory accepts the request.
- `imem_rsp_valid` in 1: response word valid.
- `imem_rsp_data` in XLEN: instruction word.
- `stall` in 1: hold IF/ID and the hold buffer.
- `redirect_valid` in 1: taken branch (pc_src).
- `redirect_pc` in XLEN: branch target.
- `if_id_valid` out 1: IF/ID entry valid.
- `if_id_pc` out XLEN: PC of the IF/ID instruction.
- `if_id_instr` out XLEN: IF/ID instruction, or `NOP_INSTR` when invalid.
- `if_id_opcode` out 7: `if_id_instr[6:0]`.

## Operation
- Internal state:
  - `pc`, next address to request.
  - `req_pc`, address of the outstanding request.
  - One-entry hold buffer `{hb_valid, hb_pc, hb_instr}`.
  - FSM with states REQ, WAIT, KILL.
- **REQ**:
  - `imem_req_valid = !hb_valid && !rst`; `imem_req_addr = pc`.
  - On a handshake (`valid && ready`): `req_pc <= pc`, `pc <= pc + 4` (mod 2^XLEN), go to WAIT.
- **WAIT**: on `imem_rsp_valid`:
  - If `!stall`: load IF/ID with `{1, req_pc, imem_rsp_data}`.
  - Else: write the response into the hold buffer.
  - Go to REQ.
- **KILL**: the outstanding response is discarded on `imem_rsp_valid`, then go to REQ. There is no request issue in KILL or WAIT; at most one request is outstanding.
- **IF/ID update when `!stall` and no response is being accepted this cycle**:
  - If `hb_valid`: load IF/ID from the buffer and clear `hb_valid`.
  - Else: `if_id_valid <= 0` (bubble).
- **IF/ID when `stall`**: IF/ID holds all fields.
- **Redirect** takes priority over stall and over a response:
  - `pc <= redirect_pc`, `if_id_valid <= 0`, `hb_valid <= 0`.
  - If a request is outstanding, or is handshaking this same cycle: go to KILL.
  - Otherwise: stay in or return to REQ.
  - A response arriving in the redirect cycle is dropped. If that response completes the outstanding request, go to REQ rather than KILL.
  - A redirect while in KILL stays in KILL and updates `pc`.
- **Invalid entry**: whenever `if_id_valid = 0`, `if_id_instr = NOP_INSTR`, so `if_id_opcode = 7'b0010011`. Decode then sees an I-type ALU op with no side effects.

## Timing
- **Reset values**:
  - `pc = RESET_PC`, FSM = REQ, `hb_valid = 0`.
  - `if_id_valid = 0`, `if_id_pc = 0`, `if_id_instr = NOP_INSTR`.
  - `imem_req_valid = 0` while `rst` is high.
- **Reset mid-operation**: the outstanding request is abandoned. Any response arriving in the cycles after reset deasserts is ignored, because the FSM is in REQ.
- **Latency**: request handshake in cycle N, response in cycle M ≥ N+1, IF/ID valid in cycle M+1.
- **Throughput**: the next request issues in cycle M+1. With a 1-cycle memory that is one instruction per 2 cycles.
- **Backpressure**: with `imem_req_ready` low, `imem_req_valid` and `imem_req_addr` stay stable until accepted, unless a redirect changes `pc`.
- **Stall with the hold buffer full**: no new request issues. When stall releases, the buffer drains into IF/ID on the next edge.
- **Response in REQ state**: ignored (protocol violation; flagged by a verification assertion).

## Test plan
1. **Reset**: hold `rst` 2 cycles, then release; memory ready and 1-cycle latency.
   - During reset: `if_id_valid = 0`, `if_id_opcode = 7'b0010011`.
   - First request address = 0x0.
   - `if_id_valid = 1` with `if_id_pc = 0x0` two cycles after the first handshake.
2. **Straight-line fetch**: memory returns 0x00500093, 0x00100113, 0x002081B3.
   - IF/ID shows PCs 0x0, 0x4, 0x8 with matching words.
   - `if_id_opcode` shows 0010011, 0010011, 0110011.
   - Bubbles appear between instructions.
3. **Stall**: assert `stall` 3 cycles while the response for 0x4 arrives.
   - IF/ID holds the 0x0 entry and the hold buffer captures 0x4.
   - No new request issues.
   - On release, IF/ID = 0x4 on the next edge.
4. **Redirect while waiting**: `redirect_valid` with `redirect_pc = 0x40` while in WAIT for 0x8; response arrives 2 cycles later.
   - IF/ID goes invalid and the response is discarded.
   - Next request address = 0x40.
5. **Redirect coincident with a response**: `redirect_pc = 0x80` in the same cycle as the response for 0xC.
   - The 0xC word never reaches IF/ID.
   - Next request is 0x80, with no KILL cycle.
6. **Backpressure and wrap**: reset with `RESET_PC = 32'hFFFF_FFFC`; `imem_req_ready` low for 4 cycles.
   - Address stays 0xFFFFFFFC until accepted.
   - Next request address = 0x0.
